// File: rtl/aes128_encrypt_iter.sv
// Iterative AES-128 forward cipher: one round per clock, round keys expanded
// on the fly from the previous round key, valid/ready handshake on both sides.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid, once raised, is held with its data until that edge, and
// ready never depends combinationally on valid (in_ready and out_valid are
// plain registers decoded with the FSM).
module aes128_encrypt_iter #(
   parameter int NR = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] plaintext,
   input  logic [127:0] key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] ciphertext
);

   // Only the 10-round AES-128 schedule is implemented.
   generate
      if (NR != 10) begin : g_nr_check
         $error("aes128_encrypt_iter: NR must be 10");
      end
   endgenerate

   localparam logic [3:0] LAST_RND = 4'(NR);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      DONE  = 2'd2
   } fsm_t;

   fsm_t              fsm;
   logic [0:15][7:0]  state;   // byte 0 = bits [127:120], column-major
   logic [127:0]      rk;      // current round key, w0 = bits [127:96]
   logic [3:0]        rnd;
   logic [7:0]        rcon;

   // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 (square-and-multiply); maps 0 to 0.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] r;
      logic [7:0] s;
      r = 8'h01;
      s = a;
      for (int i = 1; i < 8; i++) begin
         s = gf_mul(s, s);
         r = gf_mul(r, s);
      end
      return r;
   endfunction

   // Forward S-box: inverse followed by the FIPS-197 affine transform.
   // Every input is a constant-foldable function of 8 bits, so this reduces
   // to a 256-entry lookup per instance.
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] b;
      b = gf_inv(a);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
               ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   // One MixColumns column; bytes are rows 0..3 from MSB down.
   function automatic logic [31:0] mix_col(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   // Key expansion datapath: next round key from the current one.
   logic [31:0]  w3_rot, sub_w, temp;
   logic [31:0]  w0_n, w1_n, w2_n, w3_n;
   logic [127:0] next_rk;

   assign w3_rot  = {rk[23:0], rk[31:24]};
   assign sub_w   = {sbox(w3_rot[31:24]), sbox(w3_rot[23:16]),
                     sbox(w3_rot[15:8]),  sbox(w3_rot[7:0])};
   assign temp    = sub_w ^ {rcon, 24'h0};
   assign w0_n    = rk[127:96] ^ temp;
   assign w1_n    = rk[95:64]  ^ w0_n;
   assign w2_n    = rk[63:32]  ^ w1_n;
   assign w3_n    = rk[31:0]   ^ w2_n;
   assign next_rk = {w0_n, w1_n, w2_n, w3_n};

   // Round datapath: SubBytes, ShiftRows and MixColumns on the current state.
   logic [0:15][7:0] sb, sr, mc;

   always_comb begin
      sb = '0;
      sr = '0;
      mc = '0;
      for (int i = 0; i < 16; i++) begin
         sb[i] = sbox(state[i]);
      end
      // Row r of column c takes the byte from column (c + r) mod 4.
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            sr[4*c + r] = sb[4*((c + r) % 4) + r];
         end
      end
      for (int c = 0; c < 4; c++) begin
         {mc[4*c], mc[4*c + 1], mc[4*c + 2], mc[4*c + 3]} =
            mix_col({sr[4*c], sr[4*c + 1], sr[4*c + 2], sr[4*c + 3]});
      end
   end

   logic [127:0] round_out, final_out;
   assign round_out = mc ^ next_rk;
   assign final_out = sr ^ next_rk;

   // Control FSM and all datapath registers; outputs are registered here.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fsm        <= IDLE;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         ciphertext <= '0;
         state      <= '0;
         rk         <= '0;
         rnd        <= '0;
         rcon       <= 8'h01;
      end else begin
         case (fsm)
            IDLE: begin
               if (in_valid && in_ready) begin
                  state    <= plaintext ^ key;
                  rk       <= key;
                  rnd      <= 4'd1;
                  rcon     <= 8'h01;
                  in_ready <= 1'b0;
                  fsm      <= ROUND;
               end
            end
            ROUND: begin
               if (rnd > LAST_RND) begin
                  // Unreachable counter value: abandon the block.
                  rnd      <= '0;
                  in_ready <= 1'b1;
                  fsm      <= IDLE;
               end else begin
                  rk   <= next_rk;
                  rcon <= xtime(rcon);
                  if (rnd == LAST_RND) begin
                     // Final round has no MixColumns; rnd parks at its
                     // last value so it never leaves 0..10.
                     ciphertext <= final_out;
                     out_valid  <= 1'b1;
                     fsm        <= DONE;
                  end else begin
                     state <= round_out;
                     rnd   <= rnd + 4'd1;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  fsm       <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               fsm       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aes128_encrypt_iter.sv
// Bench for aes128_encrypt_iter: FIPS-197 vectors, back-pressure, reset
// mid-block, ignored input and a random back-to-back run against a
// byte-level reference model with an inverse-cipher round trip.
module tb_aes128_encrypt_iter;

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

   // ---------------- clock / reset ----------------
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b1;
   logic [127:0] plaintext = '0;
   logic [127:0] key = '0;
   logic         in_ready, out_valid;
   logic [127:0] ciphertext;

   aes128_encrypt_iter #(.NR(10)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .plaintext  (plaintext),
      .key        (key),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .ciphertext (ciphertext)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- checking ----------------
   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [7:0] sbox_t [256];
   logic [7:0] inv_t  [256];

   // S-box built by walking the multiplicative group with generator 3.
   task automatic build_tables();
      logic [7:0] p, q, x;
      p = 8'h01;
      q = 8'h01;
      for (int i = 0; i < 255; i++) begin
         p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ {q[6:0], 1'b0};
         q = q ^ {q[5:0], 2'b00};
         q = q ^ {q[3:0], 4'h0};
         if (q[7]) q = q ^ 8'h09;
         x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
         sbox_t[p] = x ^ 8'h63;
      end
      sbox_t[0] = 8'h63;
      for (int i = 0; i < 256; i++) inv_t[sbox_t[i]] = 8'(i);
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   typedef logic [0:43][31:0] ks_t;

   function automatic ks_t key_exp(input logic [127:0] k);
      ks_t w;
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]} ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      return w;
   endfunction

   function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] k);
      ks_t w;
      logic [7:0] s [4][4];
      logic [7:0] t [4][4];
      logic [127:0] out;
      w = key_exp(k);
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            s[r][c] = pt[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
      for (int rd = 1; rd <= 10; rd++) begin
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
               t[r][c] = sbox_t[s[r][(c + r) % 4]];
         for (int c = 0; c < 4; c++) begin
            if (rd < 10) begin
               s[0][c] = gmul(t[0][c], 8'h02) ^ gmul(t[1][c], 8'h03) ^ t[2][c] ^ t[3][c];
               s[1][c] = t[0][c] ^ gmul(t[1][c], 8'h02) ^ gmul(t[2][c], 8'h03) ^ t[3][c];
               s[2][c] = t[0][c] ^ t[1][c] ^ gmul(t[2][c], 8'h02) ^ gmul(t[3][c], 8'h03);
               s[3][c] = gmul(t[0][c], 8'h03) ^ t[1][c] ^ t[2][c] ^ gmul(t[3][c], 8'h02);
            end else begin
               for (int r = 0; r < 4; r++) s[r][c] = t[r][c];
            end
            for (int r = 0; r < 4; r++) s[r][c] = s[r][c] ^ w[4*rd+c][31-8*r -: 8];
         end
      end
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            out[127-8*(4*c+r) -: 8] = s[r][c];
      return out;
   endfunction

   // Inverse cipher, standing in for the team's decryption datapath.
   function automatic logic [127:0] aes_dec(input logic [127:0] ct, input logic [127:0] k);
      ks_t w;
      logic [7:0] s [4][4];
      logic [7:0] t [4][4];
      logic [127:0] out;
      w = key_exp(k);
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            s[r][c] = ct[127-8*(4*c+r) -: 8] ^ w[40+c][31-8*r -: 8];
      for (int rd = 9; rd >= 0; rd--) begin
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
               t[r][c] = inv_t[s[r][(c - r + 4) % 4]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
               s[r][c] = t[r][c] ^ w[4*rd+c][31-8*r -: 8];
         if (rd > 0) begin
            for (int c = 0; c < 4; c++) begin
               t[0][c] = gmul(s[0][c], 8'h0e) ^ gmul(s[1][c], 8'h0b) ^ gmul(s[2][c], 8'h0d) ^ gmul(s[3][c], 8'h09);
               t[1][c] = gmul(s[0][c], 8'h09) ^ gmul(s[1][c], 8'h0e) ^ gmul(s[2][c], 8'h0b) ^ gmul(s[3][c], 8'h0d);
               t[2][c] = gmul(s[0][c], 8'h0d) ^ gmul(s[1][c], 8'h09) ^ gmul(s[2][c], 8'h0e) ^ gmul(s[3][c], 8'h0b);
               t[3][c] = gmul(s[0][c], 8'h0b) ^ gmul(s[1][c], 8'h0d) ^ gmul(s[2][c], 8'h09) ^ gmul(s[3][c], 8'h0e);
               for (int r = 0; r < 4; r++) s[r][c] = t[r][c];
            end
         end
      end
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            out[127-8*(4*c+r) -: 8] = s[r][c];
      return out;
   endfunction

   // ---------------- scoreboard ----------------
   logic [127:0] exp_q [$];
   logic [127:0] pt_q  [$];
   logic [127:0] key_q [$];
   logic [127:0] sb_exp, sb_pt, sb_key;
   int acc_cnt = 0;
   int out_cnt = 0;

   always @(negedge clk) begin
      if (rst_n && in_valid && in_ready) begin
         exp_q.push_back(aes_enc(plaintext, key));
         pt_q.push_back(plaintext);
         key_q.push_back(key);
         acc_cnt++;
      end
      if (rst_n && out_valid && out_ready) begin
         out_cnt++;
         if (exp_q.size() == 0) begin
            check("sb_unexpected_out", 128'(out_valid), 128'd0);
         end else begin
            sb_exp = exp_q.pop_front();
            sb_pt  = pt_q.pop_front();
            sb_key = key_q.pop_front();
            check("sb_ct", ciphertext, sb_exp);
            check("sb_decrypt", aes_dec(ciphertext, sb_key), sb_pt);
         end
      end
   end

   // A block in flight when reset hits is discarded.
   always @(posedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         pt_q.delete();
         key_q.delete();
      end
   end

   // ---------------- driver tasks ----------------
   int acc_edge = 0;
   int out_edge = 0;
   int sends = 0;
   int exp_outs = 0;

   task automatic send(input logic [127:0] pt, input logic [127:0] k);
      bit done;
      done = 1'b0;
      @(posedge clk);
      #1;
      in_valid  = 1'b1;
      plaintext = pt;
      key       = k;
      for (int i = 0; i < 400 && !done; i++) begin
         @(negedge clk);
         if (in_ready) begin
            done     = 1'b1;
            acc_edge = cyc + 1;
         end
      end
      check("accept_seen", 128'(done), 128'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (done) sends++;
   endtask

   task automatic wait_out(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (out_valid) begin
            seen     = 1'b1;
            out_edge = cyc;
         end
      end
      check({tag, "_out_seen"}, 128'(seen), 128'd1);
   endtask

   // ---------------- stimulus ----------------
   int  spur;
   bit  found;
   bit  drv_done;
   int  target;

   initial begin
      build_tables();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Reset values.
      @(negedge clk);
      check("rst_in_ready",  128'(in_ready),   128'd1);
      check("rst_out_valid", 128'(out_valid),  128'd0);
      check("rst_ct",        ciphertext,       128'd0);
      check("rst_rk",        dut.rk,           128'd0);
      check("rst_state",     128'(dut.state),  128'd0);
      check("rst_rnd",       128'(dut.rnd),    128'd0);
      check("rst_rcon",      128'(dut.rcon),   128'h01);

      // FIPS-197 C.1 with latency.
      send(C1_PT, C1_KEY);
      exp_outs++;
      wait_out("c1");
      check("c1_latency", 128'(out_edge - acc_edge), 128'd10);
      check("c1_ct", ciphertext, C1_CT);

      // FIPS-197 Appendix B, including last round key.
      send(B_PT, B_KEY);
      exp_outs++;
      wait_out("b");
      check("b_ct", ciphertext, B_CT);
      check("b_rk10", dut.rk, B_RK10);

      // in_valid pulsed mid-block is ignored.
      send(C1_PT, C1_KEY);
      exp_outs++;
      repeat (2) @(posedge clk);
      #1;
      in_valid  = 1'b1;
      plaintext = {$urandom, $urandom, $urandom, $urandom};
      key       = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      check("ign_in_ready", 128'(in_ready), 128'd0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      wait_out("ign");
      check("ign_ct", ciphertext, C1_CT);
      check("ign_acc_count", 128'(acc_cnt), 128'(sends));

      // Back-pressure: hold out_ready low with a new block waiting.
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      send(C1_PT, C1_KEY);
      exp_outs++;
      wait_out("bp");
      @(posedge clk);
      #1;
      in_valid  = 1'b1;
      plaintext = B_PT;
      key       = B_KEY;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         check("bp_ct_hold",    ciphertext,       C1_CT);
         check("bp_valid_hold", 128'(out_valid),  128'd1);
         check("bp_ready_low",  128'(in_ready),   128'd0);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_valid_at_raise", 128'(out_valid), 128'd1);
      check("bp_ready_at_raise", 128'(in_ready),  128'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("bp_ready_after", 128'(in_ready),  128'd1);
      check("bp_valid_after", 128'(out_valid), 128'd0);
      sends++;
      exp_outs++;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      wait_out("bp2");
      check("bp2_ct", ciphertext, B_CT);

      // Reset mid-block at rnd = 5.
      send(C1_PT, B_KEY);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (dut.rnd == 4'd5) found = 1'b1;
      end
      check("rst_rnd5_seen", 128'(found), 128'd1);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst_out_valid", 128'(out_valid), 128'd0);
      check("midrst_in_ready",  128'(in_ready),  128'd1);
      spur = 0;
      repeat (15) begin
         @(negedge clk);
         if (out_valid) spur++;
      end
      check("midrst_no_spurious", 128'(spur), 128'd0);
      send(B_PT, B_KEY);
      exp_outs++;
      wait_out("midrst_b");
      check("midrst_b_ct", ciphertext, B_CT);

      // Random back-to-back traffic with random gaps and back-pressure.
      @(posedge clk);
      #1;
      drv_done = 1'b0;
      target   = exp_outs + 100;
      exp_outs = target;
      fork
         begin
            for (int n = 0; n < 100; n++) begin
               repeat ($urandom_range(0, 3)) @(posedge clk);
               send({$urandom, $urandom, $urandom, $urandom},
                    {$urandom, $urandom, $urandom, $urandom});
            end
            drv_done = 1'b1;
         end
         begin
            for (int g = 0; g < 20000 && (!drv_done || out_cnt < target); g++) begin
               @(posedge clk);
               #1;
               out_ready = 1'($urandom_range(0, 1));
            end
            out_ready = 1'b1;
         end
      join
      repeat (3) @(posedge clk);
      @(negedge clk);

      check("out_count", 128'(out_cnt), 128'(exp_outs));
      check("acc_count", 128'(acc_cnt), 128'(sends));
      check("sb_empty",  128'(exp_q.size()), 128'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
